// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit controller.
// Sequencer states, coin values and datapath widths live here.
package vend_pkg;

  localparam int CREDIT_W = 8;
  localparam int ITEM_W   = 2;

  localparam logic [CREDIT_W-1:0] NICKEL_C  = 8'd5;
  localparam logic [CREDIT_W-1:0] DIME_C    = 8'd10;
  localparam logic [CREDIT_W-1:0] QUARTER_C = 8'd25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  // Highest-value coin wins when several pulse together.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic quarter,
                                                     input logic dime,
                                                     input logic nickel);
    if (quarter)     return QUARTER_C;
    else if (dime)   return DIME_C;
    else if (nickel) return NICKEL_C;
    else             return '0;
  endfunction

endpackage

// File: rtl/vend_price_sel.sv
// Item-index to price lookup; purely combinational so the display
// logic can share it with the credit controller.
module vend_price_sel
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0 = 25,
  parameter int unsigned PRICE1 = 50,
  parameter int unsigned PRICE2 = 75,
  parameter int unsigned PRICE3 = 100
) (
  input  logic [ITEM_W-1:0]   item,
  output logic [CREDIT_W-1:0] price
);

  always_comb begin
    price = CREDIT_W'(PRICE0);
    case (item)
      2'd0:    price = CREDIT_W'(PRICE0);
      2'd1:    price = CREDIT_W'(PRICE1);
      2'd2:    price = CREDIT_W'(PRICE2);
      2'd3:    price = CREDIT_W'(PRICE3);
      default: price = CREDIT_W'(PRICE0);
    endcase
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit accumulator and vend/change sequencer for the vending machine.
// All outputs are registered; every response lands one cycle after its input pulse.
//
// state     | meaning
// ST_IDLE   | accepting coins, sel and cancel
// ST_VEND   | one-cycle dispense of the latched item
// ST_CHANGE | paying credit back one nickel per cycle
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned PRICE0     = 25,
  parameter int unsigned PRICE1     = 50,
  parameter int unsigned PRICE2     = 75,
  parameter int unsigned PRICE3     = 100,
  parameter int unsigned MAX_CREDIT = 200
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                sel,
  input  logic [ITEM_W-1:0]   item,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic                dispense,
  output logic [ITEM_W-1:0]   item_out,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic                short_funds
);

  state_t state, state_nxt;

  logic [CREDIT_W-1:0] price;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                has_credit;
  logic                any_coin;
  logic                multi_coin;
  logic                can_buy;

  logic [CREDIT_W-1:0] credit_nxt;
  logic [ITEM_W-1:0]   item_nxt;
  logic                dispense_nxt;
  logic                change_nxt;
  logic                reject_nxt;
  logic                short_nxt;

  vend_price_sel #(
    .PRICE0(PRICE0),
    .PRICE1(PRICE1),
    .PRICE2(PRICE2),
    .PRICE3(PRICE3)
  ) u_price_sel (
    .item (item),
    .price(price)
  );

  assign has_credit = (credit != '0);
  assign any_coin   = nickel | dime | quarter;
  assign multi_coin = (nickel & dime) | (nickel & quarter) | (dime & quarter);
  assign coin_val   = coin_value(quarter, dime, nickel);
  assign coin_sum   = {1'b0, credit} + {1'b0, coin_val};
  assign can_buy    = sel && (credit >= price);

  always_ff @(posedge Clk) begin
    if (Rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cancel) begin
          if (has_credit) state_nxt = ST_CHANGE;
        end else if (can_buy) begin
          state_nxt = ST_VEND;
        end
      end
      ST_VEND:   state_nxt = has_credit ? ST_CHANGE : ST_IDLE;
      ST_CHANGE: if (!has_credit) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // The first nickel is paid on the same edge that enters CHANGE, so the
  // CHANGE state with zero credit is the cycle that hands back to IDLE.
  always_comb begin
    credit_nxt   = credit;
    item_nxt     = item_out;
    dispense_nxt = 1'b0;
    change_nxt   = 1'b0;
    reject_nxt   = 1'b0;
    short_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cancel) begin
          reject_nxt = any_coin;
          if (has_credit) begin
            credit_nxt = credit - NICKEL_C;
            change_nxt = 1'b1;
          end
        end else if (can_buy) begin
          reject_nxt   = any_coin;
          item_nxt     = item;
          credit_nxt   = credit - price;
          dispense_nxt = 1'b1;
        end else begin
          short_nxt  = sel;
          reject_nxt = multi_coin;
          if (any_coin) begin
            if (coin_sum > (CREDIT_W + 1)'(MAX_CREDIT)) reject_nxt = 1'b1;
            else                                          credit_nxt = coin_sum[CREDIT_W-1:0];
          end
        end
      end
      ST_VEND, ST_CHANGE: begin
        reject_nxt = any_coin;
        if (has_credit) begin
          credit_nxt = credit - NICKEL_C;
          change_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      credit        <= '0;
      item_out      <= '0;
      dispense      <= 1'b0;
      change_nickel <= 1'b0;
      coin_reject   <= 1'b0;
      short_funds   <= 1'b0;
    end else begin
      credit        <= credit_nxt;
      item_out      <= item_nxt;
      dispense      <= dispense_nxt;
      change_nickel <= change_nxt;
      coin_reject   <= reject_nxt;
      short_funds   <= short_nxt;
    end
  end

  a_no_underflow : assert property (@(posedge Clk) disable iff (Rst)
                                    change_nxt |-> (credit >= NICKEL_C));

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed self-checking bench for vend_credit_ctrl with default prices.
// Inputs change 1ns after the rising edge; outputs are read at the same point.
module tb_vend_credit_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       nickel, dime, quarter, sel, cancel;
  logic [1:0] item;
  logic [7:0] credit;
  logic       dispense;
  logic [1:0] item_out;
  logic       change_nickel, coin_reject, short_funds;

  int errors = 0;
  int checks = 0;

  vend_credit_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .nickel       (nickel),
    .dime         (dime),
    .quarter      (quarter),
    .sel          (sel),
    .item         (item),
    .cancel       (cancel),
    .credit       (credit),
    .dispense     (dispense),
    .item_out     (item_out),
    .change_nickel(change_nickel),
    .coin_reject  (coin_reject),
    .short_funds  (short_funds)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_in();
    nickel = 0; dime = 0; quarter = 0; sel = 0; cancel = 0; item = 2'd0;
  endtask

  task automatic test_reset();
    clr_in();
    Rst = 1;
    tick(); tick();
    Rst = 0;
    checks++; if (credit !== 8'd0) begin errors++; $display("FAIL reset_credit got=%0d exp=0", credit); end
    checks++; if (item_out !== 2'd0) begin errors++; $display("FAIL reset_item_out got=%0d exp=0", item_out); end
    checks++; if ({dispense, change_nickel, coin_reject, short_funds} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {dispense, change_nickel, coin_reject, short_funds});
    end
  endtask

  task automatic test_coin_entry();
    quarter = 1; tick(); clr_in();
    checks++; if (credit !== 8'd25 || coin_reject !== 1'b0) begin errors++; $display("FAIL coin_quarter got=%0d/%b exp=25/0", credit, coin_reject); end
    dime = 1; tick(); clr_in();
    checks++; if (credit !== 8'd35 || coin_reject !== 1'b0) begin errors++; $display("FAIL coin_dime got=%0d/%b exp=35/0", credit, coin_reject); end
    nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd40 || coin_reject !== 1'b0) begin errors++; $display("FAIL coin_nickel got=%0d/%b exp=40/0", credit, coin_reject); end
  endtask

  task automatic test_purchase();
    sel = 1; item = 2'd0; tick(); clr_in();
    checks++; if (dispense !== 1'b1 || item_out !== 2'd0 || credit !== 8'd15) begin
      errors++; $display("FAIL vend_cycle got disp=%b item=%0d credit=%0d exp 1/0/15", dispense, item_out, credit);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++; if (change_nickel !== 1'b1 || credit !== 8'(15 - 5 * i) || dispense !== 1'b0) begin
        errors++; $display("FAIL vend_change%0d got chg=%b credit=%0d exp 1/%0d", i, change_nickel, credit, 15 - 5 * i);
      end
    end
    tick();
    checks++; if (change_nickel !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL vend_train_end got chg=%b credit=%0d exp 0/0", change_nickel, credit); end
    quarter = 1; tick(); clr_in();
    checks++; if (credit !== 8'd25 || coin_reject !== 1'b0) begin errors++; $display("FAIL vend_back_idle got=%0d/%b exp=25/0", credit, coin_reject); end
    dime = 1; tick(); clr_in();
    nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd40) begin errors++; $display("FAIL refill_40 got=%0d exp=40", credit); end
  endtask

  task automatic test_short_cancel();
    sel = 1; item = 2'd1; tick(); clr_in();
    checks++; if (short_funds !== 1'b1 || credit !== 8'd40 || dispense !== 1'b0) begin
      errors++; $display("FAIL short_pulse got sf=%b credit=%0d disp=%b exp 1/40/0", short_funds, credit, dispense);
    end
    tick();
    checks++; if (short_funds !== 1'b0) begin errors++; $display("FAIL short_one_cycle got=%b exp=0", short_funds); end
    cancel = 1; tick(); clr_in();
    for (int i = 1; i <= 8; i++) begin
      checks++; if (change_nickel !== 1'b1 || credit !== 8'(40 - 5 * i)) begin
        errors++; $display("FAIL cancel_change%0d got chg=%b credit=%0d exp 1/%0d", i, change_nickel, credit, 40 - 5 * i);
      end
      tick();
    end
    checks++; if (change_nickel !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL cancel_end got chg=%b credit=%0d exp 0/0", change_nickel, credit); end
    tick();
    cancel = 1; tick(); clr_in();
    checks++; if (change_nickel !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL cancel_zero got chg=%b credit=%0d exp 0/0", change_nickel, credit); end
  endtask

  task automatic test_simul_coins();
    Rst = 1; tick(); Rst = 0;
    dime = 1; nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd10 || coin_reject !== 1'b1) begin errors++; $display("FAIL dime_nickel got=%0d/%b exp=10/1", credit, coin_reject); end
    quarter = 1; dime = 1; nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd35 || coin_reject !== 1'b1) begin errors++; $display("FAIL three_coins got=%0d/%b exp=35/1", credit, coin_reject); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL reject_one_cycle got=%b exp=0", coin_reject); end
    for (int i = 0; i < 6; i++) begin quarter = 1; tick(); clr_in(); end
    nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd190) begin errors++; $display("FAIL fill_190 got=%0d exp=190", credit); end
    quarter = 1; tick(); clr_in();
    checks++; if (credit !== 8'd190 || coin_reject !== 1'b1) begin errors++; $display("FAIL ceiling_quarter got=%0d/%b exp=190/1", credit, coin_reject); end
    dime = 1; tick(); clr_in();
    checks++; if (credit !== 8'd200 || coin_reject !== 1'b0) begin errors++; $display("FAIL ceiling_exact got=%0d/%b exp=200/0", credit, coin_reject); end
    nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd200 || coin_reject !== 1'b1) begin errors++; $display("FAIL ceiling_nickel got=%0d/%b exp=200/1", credit, coin_reject); end
  endtask

  task automatic test_busy_reset();
    sel = 1; item = 2'd3; tick(); clr_in();
    checks++; if (dispense !== 1'b1 || item_out !== 2'd3 || credit !== 8'd100) begin
      errors++; $display("FAIL vend_item3 got disp=%b item=%0d credit=%0d exp 1/3/100", dispense, item_out, credit);
    end
    nickel = 1; tick(); clr_in();
    checks++; if (coin_reject !== 1'b1 || change_nickel !== 1'b1 || credit !== 8'd95) begin
      errors++; $display("FAIL busy_vend_coin got rej=%b chg=%b credit=%0d exp 1/1/95", coin_reject, change_nickel, credit);
    end
    nickel = 1; sel = 1; item = 2'd0; tick(); clr_in();
    checks++; if (coin_reject !== 1'b1 || change_nickel !== 1'b1 || credit !== 8'd90 || short_funds !== 1'b0 || dispense !== 1'b0) begin
      errors++; $display("FAIL busy_change got rej=%b chg=%b credit=%0d sf=%b disp=%b exp 1/1/90/0/0", coin_reject, change_nickel, credit, short_funds, dispense);
    end
    cancel = 1; tick(); clr_in();
    checks++; if (change_nickel !== 1'b1 || credit !== 8'd85 || coin_reject !== 1'b0) begin
      errors++; $display("FAIL busy_cancel got chg=%b credit=%0d rej=%b exp 1/85/0", change_nickel, credit, coin_reject);
    end
    Rst = 1; tick(); Rst = 0;
    checks++; if (credit !== 8'd0 || change_nickel !== 1'b0 || item_out !== 2'd0) begin
      errors++; $display("FAIL mid_reset got credit=%0d chg=%b item=%0d exp 0/0/0", credit, change_nickel, item_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (change_nickel !== 1'b0 || credit !== 8'd0) begin errors++; $display("FAIL post_reset%0d got chg=%b credit=%0d exp 0/0", i, change_nickel, credit); end
    end
    nickel = 1; tick(); clr_in();
    checks++; if (credit !== 8'd5 || coin_reject !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%0d/%b exp=5/0", credit, coin_reject); end
  endtask

  task automatic test_back_to_back();
    quarter = 1; tick(); clr_in();
    sel = 1; item = 2'd0; dime = 1; tick(); clr_in();
    checks++; if (dispense !== 1'b1 || credit !== 8'd5 || coin_reject !== 1'b1) begin
      errors++; $display("FAIL sel_with_coin got disp=%b credit=%0d rej=%b exp 1/5/1", dispense, credit, coin_reject);
    end
    tick();
    checks++; if (change_nickel !== 1'b1 || credit !== 8'd0) begin errors++; $display("FAIL sel_change got chg=%b credit=%0d exp 1/0", change_nickel, credit); end
    tick();
    checks++; if (change_nickel !== 1'b0) begin errors++; $display("FAIL sel_train_end got=%b exp=0", change_nickel); end
    nickel = 1; tick(); clr_in();
    cancel = 1; quarter = 1; tick(); clr_in();
    checks++; if (change_nickel !== 1'b1 || credit !== 8'd0 || coin_reject !== 1'b1) begin
      errors++; $display("FAIL cancel_with_coin got chg=%b credit=%0d rej=%b exp 1/0/1", change_nickel, credit, coin_reject);
    end
    tick();
    checks++; if (change_nickel !== 1'b0 || coin_reject !== 1'b0) begin errors++; $display("FAIL cancel_coin_end got chg=%b rej=%b exp 0/0", change_nickel, coin_reject); end
  endtask

  initial begin
    Rst = 1;
    clr_in();
    test_reset();
    test_coin_entry();
    test_purchase();
    test_short_cancel();
    test_simul_coins();
    test_busy_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Credit accumulator and vend sequencer for the vending machine. It consumes the single-cycle, one-per-press pulses produced by the button synchronizer stage: coin inserts, item select and cancel. It keeps a running credit in cents, dispenses an item when credit covers its price, and then pays change back as a train of nickel pulses.

## Interface
- PRICE0, 25, price of item 0 in cents; must be a multiple of 5, ≤ MAX_CREDIT
- PRICE1, 50, price of item 1 in cents; same constraints
- PRICE2, 75, price of item 2 in cents; same constraints
- PRICE3, 100, price of item 3 in cents; same constraints
- MAX_CREDIT, 200, credit ceiling in cents; must be a multiple of 5, ≤ 255
- Clk  in  1  single clock; all state changes on its rising edge
- Rst  in  1  synchronous, active-high reset
- nickel  in  1  one-cycle pulse: 5c inserted
- dime  in  1  one-cycle pulse: 10c inserted
- quarter  in  1  one-cycle pulse: 25c inserted
- sel  in  1  one-cycle pulse: purchase request
- item  in  2  item index; sampled only when sel=1
- cancel  in  1  one-cycle pulse: refund all credit
- credit  out  8  current credit in cents (registered)
- dispense  out  1  one-cycle pulse: release item
- item_out  out  2  dispensed item index; valid when dispense=1
- change_nickel  out  1  one pulse per 5c returned
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted
- short_funds  out  1  one-cycle pulse: sel with credit < price

## Operation
- The FSM has three states: IDLE, VEND, CHANGE. Reset puts it in IDLE.
- Reset values: credit=0, item_out=0, and all pulse outputs 0.
- IDLE, evaluated in this priority order each cycle:
  - cancel=1:
    - If credit>0, go to CHANGE.
    - If credit=0, do nothing.
    - Any coin in the same cycle is rejected.
  - sel=1 and credit ≥ PRICE[item]:
    - Latch item into item_out.
    - credit ← credit − PRICE[item].
    - Go to VEND.
    - Any coin in the same cycle is rejected.
  - sel=1 and credit < PRICE[item]:
    - Pulse short_funds next cycle.
    - credit is unchanged.
    - Any coin in the same cycle is still processed under the coin rules below.
- Coin rules:
  - When more than one coin pulse is high in a cycle, only the highest value is taken (quarter > dime > nickel). The others produce coin_reject.
  - If the taken coin would push credit above MAX_CREDIT, it is rejected and credit is unchanged.
  - coin_reject is a single-cycle pulse regardless of how many coins are rejected at once.
- VEND (exactly 1 cycle):
  - dispense=1 and item_out holds the latched index.
  - Next state is CHANGE if credit>0, otherwise IDLE.
- CHANGE:
  - Each cycle: change_nickel=1 and credit ← credit − 5.
  - Leave for IDLE on the cycle credit reaches 0.
- In VEND and CHANGE:
  - Every coin pulse produces coin_reject.
  - sel and cancel are ignored, with no short_funds.
- credit is always a multiple of 5. Subtraction cannot underflow; an assertion checks this in simulation.
- Rst is valid in any state. It aborts a vend or change train immediately, and no further pulses are emitted.

## Timing
- Outputs are registered. A response appears in the cycle after the input pulse.
- Coin accepted at cycle n: credit is updated at n+1.
- sel at cycle n with enough credit:
  - credit is reduced and dispense=1 at n+1.
  - The first change_nickel is at n+2.
  - The last change_nickel is at n+1+(credit_remaining/5); IDLE follows on the next cycle.
- Worst-case lockout with MAX_CREDIT=200 and a 25c item: 1 + 35 cycles.
- short_funds and coin_reject are asserted at n+1 for events at n.

## Structure
- Package vend_pkg holds:
  - state encoding (IDLE/VEND/CHANGE)
  - coin value constants (5/10/25)
  - CREDIT_W=8
  - the ITEM_W=2 width
- Sub-module vend_price_sel: a combinational 4:1 mux from item to PRICEx. It is parameterized by PRICE0..3 and shared with the display logic.
- Core: one state register, one credit register, and registered pulse outputs.

## Test plan
- Coin entry:
  - Stimulus: reset; pulse quarter, dime, nickel on separate cycles.
  - Required response: credit reads 25, 35, 40, one cycle after each pulse; no rejects.
- Purchase with change:
  - Stimulus: credit 40; sel with item=0 (25c).
  - Required response:
    - Next cycle: dispense=1, item_out=0, credit=15.
    - Then exactly 3 change_nickel pulses, with credit ending at 0.
    - IDLE on the following cycle.
- Short funds and cancel:
  - Stimulus: credit 40, sel with item=1 (50c).
  - Required response: short_funds=1 for 1 cycle; credit stays 40.
  - Then pulse cancel: 8 change_nickel pulses and credit reaches 0.
- Simultaneous coins and ceiling:
  - Stimulus: dime and nickel in the same cycle.
  - Required response: credit +10 and coin_reject=1.
  - Then, from credit 190, a quarter → rejected, credit stays 190.
- Busy rejection and reset:
  - Stimulus: during CHANGE, pulse nickel and sel.
  - Required response: coin_reject=1, no short_funds, change train unaffected.
  - Then assert Rst mid-train: next cycle credit=0, IDLE, no further change_nickel.
